// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package nibble_serial_add_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_full_4bit_adder.sv
// Shared 4-bit adder; the sequencer reuses it once per nibble.
module full_4bit_adder
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract done one nibble per clock through a single 4-bit adder.
// state   | meaning
// IDLE    | waiting for a request, in_ready high
// RUN     | one nibble per edge, LSB first
// DONE    | result held until out_ready
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int              CNT_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  state_t              state, state_nxt;
  logic [W-1:0]        a_sh, b_sh, res;
  logic [W-1:0]        b_eff;
  logic                carry, a_msb, b_msb;
  logic [CNT_W-1:0]    cnt;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;
  logic                accept;

  assign b_eff  = sub ? ~b : b;
  assign accept = in_valid && (state == ST_IDLE);

  full_4bit_adder u_adder (
    .a   (a_sh[NIBBLE_W-1:0]),
    .b   (b_sh[NIBBLE_W-1:0]),
    .cin (carry),
    .sum (nib_sum),
    .cout(nib_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)          state_nxt = ST_RUN;
      ST_RUN:  if (cnt == CNT_LAST) state_nxt = ST_DONE;
      ST_DONE: if (out_ready)       state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // Subtract is a + ~b + ~borrow_in, so the carry register holds NOT-borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b_eff;
      carry <= sub ^ cin;
      a_msb <= a[W-1];
      b_msb <= b_eff[W-1];
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      a_sh  <= {NIBBLE_W'(0), a_sh[W-1:NIBBLE_W]};
      b_sh  <= {NIBBLE_W'(0), b_sh[W-1:NIBBLE_W]};
      res   <= {nib_sum, res[W-1:NIBBLE_W]};
      carry <= nib_cout;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // Result outputs are gated to DONE so a partial sum never appears.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sum       = '0;
    cout      = 1'b0;
    ovf       = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        sum       = res;
        cout      = carry;
        ovf       = (a_msb == b_msb) && (res[W-1] != a_msb);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed and randomized checks of the nibble-serial sequencer against an integer model.
module tb_nibble_serial_add_ctrl;

  localparam int N  = 4;
  localparam int WW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [WW-1:0] a, b;
  logic          cin, sub;
  logic          out_valid, out_ready;
  logic [WW-1:0] sum;
  logic          cout, ovf;

  int checks = 0;
  int errors = 0;

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result as plain integer arithmetic: a+b+cin or a-b-cin, with signed range test for overflow.
  task automatic model(input logic [WW-1:0] x, input logic [WW-1:0] y, input logic c,
                       input logic s, output logic [WW-1:0] r, output logic co, output logic ov);
    longint sx, sy, cc, sr;
    logic [WW:0] full;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    cc = c ? 64'sd1 : 64'sd0;
    if (!s) begin
      full = {1'b0, x} + {1'b0, y} + (WW+1)'(c);
      co   = full[WW];
      sr   = sx + sy + cc;
    end else begin
      full = {1'b0, x} - {1'b0, y} - (WW+1)'(c);
      co   = ~full[WW];
      sr   = sx - sy - cc;
    end
    r  = full[WW-1:0];
    ov = (sr > 64'sd32767) || (sr < -64'sd32768);
  endtask

  task automatic wait_done(input string tag);
    int edges;
    edges = 0;
    while (!out_valid && edges < 20) begin
      if (edges == 1) check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
      in_valid = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), 32'(N));
  endtask

  task automatic run_op(input string tag, input logic [WW-1:0] oa, input logic [WW-1:0] ob,
                        input logic oc, input logic os, input int hold);
    logic [WW-1:0] es, s0;
    logic ec, eo;
    model(oa, ob, oc, os, es, ec, eo);
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    a = oa; b = ob; cin = oc; sub = os; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cin = 1'($urandom);
    sub = 1'($urandom);
    wait_done(tag);
    check({tag, "_sum"},  32'(sum),  32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"},  32'(ovf),  32'(eo));
    s0 = sum;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      a = 16'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_sum"},   32'(sum),      32'(s0));
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_consumed"},   32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    logic [WW-1:0] es, hs;
    logic ec, eo, hc, ho;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_basic",  16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run_op("add_carry",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
    run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op("add_cin",    16'h0000, 16'h0000, 1'b1, 1'b0, 2);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    run_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    run_op("sub_bin",    16'h0000, 16'h0000, 1'b1, 1'b1, 0);

    // Backpressure: 10 stalled cycles in DONE with noisy inputs.
    model(16'h8000, 16'h8000, 1'b0, 1'b0, es, ec, eo);
    @(negedge clk);
    a = 16'h8000; b = 16'h8000; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done("bp");
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      check("bp_sum",      32'(sum),      32'(es));
      check("bp_cout",     32'(cout),     32'(ec));
      check("bp_ovf",      32'(ovf),      32'(eo));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid",    32'(out_valid), 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready),  32'd1);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_sum",   32'(sum),       32'd0);
    check("midrst_ready", 32'(in_ready),  32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_held_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 16'h0100, 16'h0F00, 1'b0, 1'b0, 0);

    for (int k = 0; k < 24; k++) begin
      hs = 16'($urandom);
      hc = 1'($urandom);
      ho = 1'($urandom);
      run_op("rand", hs, 16'($urandom), hc, ho, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
